// File: rtl/jt900h_dmp_seq.sv
// Register-dump sequencer: walks the jt900h_regs dump port and streams a framed
// packet (header, 82 data bytes, two's-complement checksum) over a valid/ready byte port.
module jt900h_dmp_seq #(
   parameter logic [7:0] HEADER = 8'hA5,
   parameter logic [7:0] LAST   = 8'd81
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cen,
   input  logic       start,
   output logic       busy,
   output logic       hold,
   output logic       done,
   output logic [7:0] dmp_addr,
   input  logic [7:0] dmp_dout,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready
);

   typedef enum logic [2:0] {
      StIdle,
      StHdr,
      StRd,
      StDat,
      StSum,
      StFin
   } state_e;

   state_e     state_q, state_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       valid_q, valid_d;
   logic [7:0] data_q, data_d;
   logic [7:0] addr_q, addr_d;
   logic [7:0] acc_q, acc_d;
   logic [7:0] acc_sum;
   logic       xfer;

   always_comb begin
      state_d = state_q;
      busy_d  = busy_q;
      done_d  = done_q;
      valid_d = valid_q;
      data_d  = data_q;
      addr_d  = addr_q;
      acc_d   = acc_q;
      acc_sum = acc_q + data_q;
      xfer    = valid_q & out_ready;
      // With cen low every register keeps its value, so no handshake can be taken.
      if (cen) begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_d = StHdr;
                  data_d  = HEADER;
                  valid_d = 1'b1;
                  busy_d  = 1'b1;
                  acc_d   = 8'h00;
               end
            end
            StHdr: begin
               if (xfer) begin
                  addr_d  = 8'h00;
                  valid_d = 1'b0;
                  state_d = StRd;
               end
            end
            StRd: begin
               // Bubble cycle: dmp_dout settles for the address set on the previous edge.
               data_d  = dmp_dout;
               valid_d = 1'b1;
               state_d = StDat;
            end
            StDat: begin
               if (xfer) begin
                  acc_d = acc_sum;
                  if (addr_q == LAST) begin
                     data_d  = 8'h00 - acc_sum;
                     state_d = StSum;
                  end else begin
                     addr_d  = addr_q + 8'd1;
                     valid_d = 1'b0;
                     state_d = StRd;
                  end
               end
            end
            StSum: begin
               if (xfer) begin
                  valid_d = 1'b0;
                  done_d  = 1'b1;
                  state_d = StFin;
               end
            end
            StFin: begin
               done_d  = 1'b0;
               busy_d  = 1'b0;
               state_d = StIdle;
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         data_q  <= 8'h00;
         addr_q  <= 8'h00;
         acc_q   <= 8'h00;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         addr_q  <= addr_d;
         acc_q   <= acc_d;
      end
   end

   assign busy      = busy_q;
   assign hold      = busy_q;
   assign done      = done_q;
   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign dmp_addr  = addr_q;

endmodule

// File: tb/tb_jt900h_dmp_seq.sv
// Scoreboard bench for jt900h_dmp_seq: expected frames are queued at start, a negedge
// monitor pops one entry per accepted byte and checks framing, checksum and hold stability.
module tb_jt900h_dmp_seq;

   localparam logic [7:0] HDR = 8'hA5;
   localparam logic [7:0] LST = 8'd81;
   localparam logic [1:0] KHDR = 2'd0;
   localparam logic [1:0] KDAT = 2'd1;
   localparam logic [1:0] KSUM = 2'd2;

   typedef struct packed {
      logic [7:0] data;
      logic [7:0] addr;
      logic [1:0] kind;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cen = 1'b1;
   logic       start = 1'b0;
   logic       busy, hold, done;
   logic [7:0] dmp_addr, dmp_dout, out_data;
   logic       out_valid;
   logic       out_ready = 1'b1;

   logic [7:0] regs [0:255];
   exp_t       exp_q [$];
   int         vectors = 0;
   int         errors = 0;
   int         pops = 0;
   int         done_cnt = 0;
   int         cen_mode = 0;
   int         ready_mode = 0;
   logic [7:0] last_chk = 8'h00;

   assign dmp_dout = regs[dmp_addr];

   jt900h_dmp_seq #(.HEADER(HDR), .LAST(LST)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cen      (cen),
      .start    (start),
      .busy     (busy),
      .hold     (hold),
      .done     (done),
      .dmp_addr (dmp_addr),
      .dmp_dout (dmp_dout),
      .out_data (out_data),
      .out_valid(out_valid),
      .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input bit ok, input string name, input logic [31:0] act,
                        input logic [31:0] req);
      vectors++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
      end
   endtask

   // cen and out_ready change 1 time unit after each edge; stimulus acts 2 units after.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         cen       = (cen_mode != 0) ? ~cen : 1'b1;
         out_ready = (ready_mode != 0) ? ($urandom_range(0, 99) < 30) : 1'b1;
      end
   end

   // Monitor: values at the negedge are those the DUT sees at the next rising edge.
   initial begin
      logic       prev_valid = 1'b0;
      logic       prev_hs = 1'b0;
      logic       done_prev = 1'b0;
      logic [7:0] prev_data = 8'h00;
      logic [7:0] prev_addr = 8'h00;
      logic [7:0] fsum = 8'h00;
      logic       hs;
      exp_t       e;
      forever begin
         @(negedge clk);
         hs = rst_n && cen && out_valid && out_ready;
         check(hold == busy, "hold_eq_busy", hold, busy);
         check(dmp_addr <= LST, "addr_bound", dmp_addr, LST);
         if (rst_n && prev_valid && !prev_hs && out_valid) begin
            check(out_data == prev_data, "hold_data", out_data, prev_data);
            check(dmp_addr == prev_addr, "hold_addr", dmp_addr, prev_addr);
         end
         if (hs) begin
            if (exp_q.size() == 0) begin
               check(1'b0, "unexpected_byte", out_data, 0);
            end else begin
               e = exp_q.pop_front();
               pops++;
               check(out_data == e.data, "stream_byte", out_data, e.data);
               if (e.kind == KDAT) begin
                  check(dmp_addr == e.addr, "byte_addr", dmp_addr, e.addr);
                  fsum = fsum + out_data;
               end else if (e.kind == KHDR) begin
                  fsum = 8'h00;
               end else begin
                  check(8'(fsum + out_data) == 8'h00, "frame_sum_zero",
                        8'(fsum + out_data), 0);
                  last_chk = out_data;
               end
            end
         end
         if (done && !done_prev) done_cnt++;
         if (done && cen_mode == 0) check(!done_prev, "done_one_cycle", done_prev, 0);
         done_prev  = done;
         prev_valid = rst_n && out_valid;
         prev_hs    = hs;
         prev_data  = out_data;
         prev_addr  = dmp_addr;
      end
   end

   initial begin
      #(10 * 90000);
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic push_frame;
      logic [7:0] s;
      s = 8'h00;
      exp_q.push_back('{data: HDR, addr: 8'h00, kind: KHDR});
      for (int i = 0; i <= int'(LST); i++) begin
         exp_q.push_back('{data: regs[i], addr: 8'(i), kind: KDAT});
         s = s + regs[i];
      end
      exp_q.push_back('{data: 8'h00 - s, addr: LST, kind: KSUM});
   endtask

   // Duration = cycles from the first cycle start is high through the last busy cycle.
   // In alternate-cen mode start is held two cycles, aligned so the first one has cen=0.
   task automatic do_frame(output int dur);
      int d0, nst;
      nst = (cen_mode != 0) ? 2 : 1;
      if (cen_mode != 0 && cen) tick();
      d0 = done_cnt;
      push_frame();
      start = 1'b1;
      dur = 0;
      do begin
         tick();
         dur++;
         if (dur == nst) start = 1'b0;
      end while ((busy || dur < nst) && dur < 4000);
      start = 1'b0;
      check(dur < 4000, "frame_timeout", dur, 4000);
      check(done_cnt - d0 == 1, "done_pulses", done_cnt - d0, 1);
      check(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
   endtask

   task automatic wait_pops(input int n);
      int t;
      t = 0;
      while (pops < n && t < 2000) begin
         tick();
         t++;
      end
      check(pops >= n, "wait_pops", pops, n);
   endtask

   initial begin
      int dur, d0, t;
      for (int i = 0; i < 256; i++) regs[i] = 8'h00;
      regs[77] = 8'h01;
      regs[80] = 8'hF8;

      // Reset state
      rst_n = 1'b0;
      repeat (3) tick();
      check(out_valid == 1'b0, "rst_valid", out_valid, 0);
      check(busy == 1'b0, "rst_busy", busy, 0);
      check(hold == 1'b0, "rst_hold", hold, 0);
      check(done == 1'b0, "rst_done", done, 0);
      check(out_data == 8'h00, "rst_data", out_data, 0);
      check(dmp_addr == 8'h00, "rst_addr", dmp_addr, 0);
      rst_n = 1'b1;
      tick();

      // Reset-state dump, ready held high
      do_frame(dur);
      check(dur == 168, "frame_cycles", dur, 168);
      check(last_chk == 8'h07, "reset_checksum", last_chk, 8'h07);

      // Backpressure
      ready_mode = 1;
      do_frame(dur);
      check(last_chk == 8'h07, "bp_checksum", last_chk, 8'h07);
      ready_mode = 0;
      tick();

      // Alternate-cycle clock enable
      cen_mode = 1;
      do_frame(dur);
      check(dur == 336, "cen_frame_cycles", dur, 336);
      check(last_chk == 8'h07, "cen_checksum", last_chk, 8'h07);
      cen_mode = 0;
      repeat (2) tick();

      // Start while busy: at data byte 10 and in FIN
      d0 = done_cnt;
      push_frame();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_pops(pops + 11);
      start = 1'b1;
      tick();
      start = 1'b0;
      t = 0;
      while (!done && t < 2000) begin
         tick();
         t++;
      end
      check(done == 1'b1, "reach_fin", done, 1);
      start = 1'b1;
      tick();
      start = 1'b0;
      check(busy == 1'b0, "fin_start_ignored", busy, 0);
      check(done_cnt - d0 == 1, "single_done", done_cnt - d0, 1);
      check(exp_q.size() == 0, "single_frame", exp_q.size(), 0);
      push_frame();
      start = 1'b1;
      tick();
      start = 1'b0;
      check(busy == 1'b1, "idle_start_taken", busy, 1);
      t = 0;
      while (busy && t < 2000) begin
         tick();
         t++;
      end
      check(done_cnt - d0 == 2, "second_frame_done", done_cnt - d0, 2);
      check(exp_q.size() == 0, "second_frame_drained", exp_q.size(), 0);

      // Reset mid-frame at data byte 40
      tick();
      d0 = pops;
      push_frame();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_pops(d0 + 41);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      exp_q.delete();
      check(out_valid == 1'b0, "mid_rst_valid", out_valid, 0);
      check(dmp_addr == 8'h00, "mid_rst_addr", dmp_addr, 0);
      check(busy == 1'b0, "mid_rst_busy", busy, 0);
      check(done == 1'b0, "mid_rst_done", done, 0);
      d0 = done_cnt;
      repeat (4) tick();
      check(done_cnt == d0, "mid_rst_no_done", done_cnt, d0);
      do_frame(dur);
      check(dur == 168, "post_rst_cycles", dur, 168);

      // Random register contents, 20 frames under backpressure
      ready_mode = 1;
      for (int f = 0; f < 20; f++) begin
         for (int i = 0; i <= int'(LST); i++) regs[i] = 8'($urandom_range(0, 255));
         do_frame(dur);
         tick();
      end
      ready_mode = 0;
      repeat (3) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
